// File: rtl/mem_pkg.sv
// mem_pkg: shared constants for the MEM-stage access unit.
// Optional misalignment trap is enabled by defining MEM_ALIGN_CHECK_EN.
package mem_pkg;
    localparam int RegAddrBus = 5;
    localparam int RegBus     = 32;

    localparam logic WriteEnable  = 1'b1;
    localparam logic WriteDisable = 1'b0;

    localparam logic [7:0] EXE_LB_OP  = 8'hE0;
    localparam logic [7:0] EXE_LH_OP  = 8'hE1;
    localparam logic [7:0] EXE_LW_OP  = 8'hE3;
    localparam logic [7:0] EXE_LBU_OP = 8'hE4;
    localparam logic [7:0] EXE_LHU_OP = 8'hE5;
    localparam logic [7:0] EXE_SB_OP  = 8'hE8;
    localparam logic [7:0] EXE_SH_OP  = 8'hE9;
    localparam logic [7:0] EXE_SW_OP  = 8'hEB;

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] BUS  = 1'b1;

    function automatic logic is_load_op(input logic [7:0] op);
        return op inside {EXE_LB_OP, EXE_LBU_OP, EXE_LH_OP, EXE_LHU_OP, EXE_LW_OP};
    endfunction

    function automatic logic is_store_op(input logic [7:0] op);
        return op inside {EXE_SB_OP, EXE_SH_OP, EXE_SW_OP};
    endfunction

    function automatic logic is_byte_op(input logic [7:0] op);
        return op inside {EXE_LB_OP, EXE_LBU_OP, EXE_SB_OP};
    endfunction

    function automatic logic is_half_op(input logic [7:0] op);
        return op inside {EXE_LH_OP, EXE_LHU_OP, EXE_SH_OP};
    endfunction

    function automatic logic is_word_op(input logic [7:0] op);
        return op inside {EXE_LW_OP, EXE_SW_OP};
    endfunction
endpackage

// File: rtl/mem_lane_align.sv
// mem_lane_align: big-endian byte-lane selects, store replication and load extraction.
module mem_lane_align
    import mem_pkg::*;
(
    input  logic [7:0]  aluop,
    input  logic [1:0]  addr,
    input  logic [31:0] store_data,
    input  logic [31:0] rdata,
    output logic [3:0]  sel,
    output logic [31:0] wdata,
    output logic [31:0] load_data
);
    logic [7:0]  rbyte;
    logic [15:0] rhalf;

    // Lane 00 is the most significant byte on a big-endian bus.
    assign rbyte = 8'(rdata >> {~addr, 3'b000});
    assign rhalf = addr[1] ? rdata[15:0] : rdata[31:16];

    always_comb begin
        sel = is_byte_op(aluop) ? 4'b1000 >> addr :
              is_half_op(aluop) ? (addr[1] ? 4'b0011 : 4'b1100) :
              is_word_op(aluop) ? 4'b1111 : 4'b0000;
        wdata = (aluop == EXE_SB_OP) ? {4{store_data[7:0]}} :
                (aluop == EXE_SH_OP) ? {2{store_data[15:0]}} : store_data;
        load_data = (aluop == EXE_LB_OP)  ? {{24{rbyte[7]}}, rbyte} :
                    (aluop == EXE_LBU_OP) ? {24'h0, rbyte} :
                    (aluop == EXE_LH_OP)  ? {{16{rhalf[15]}}, rhalf} :
                    (aluop == EXE_LHU_OP) ? {16'h0, rhalf} : rdata;
    end
endmodule

// File: rtl/mem_access.sv
// mem_access: MEM-stage load/store unit driving a req/ack bus master; doubles as MEM/WB register.
// Define MEM_ALIGN_CHECK_EN to trap misaligned half/word accesses via misalign_exc.
module mem_access
    import mem_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [RegAddrBus-1:0] mem_wd,
    input  logic                  mem_wreg,
    input  logic [DATA_W-1:0]     mem_wdata,
    input  logic [7:0]            mem_aluop,
    input  logic [ADDR_W-1:0]     mem_addr,
    input  logic [DATA_W-1:0]     mem_store_data,
    output logic [RegAddrBus-1:0] wb_wd,
    output logic                  wb_wreg,
    output logic [DATA_W-1:0]     wb_wdata,
    output logic                  stallreq,
    output logic                  bus_req,
    output logic                  bus_we,
    output logic [ADDR_W-1:0]     bus_addr,
    output logic [3:0]            bus_sel,
    output logic [DATA_W-1:0]     bus_wdata,
`ifdef MEM_ALIGN_CHECK_EN
    output logic                  misalign_exc,
`endif
    input  logic [DATA_W-1:0]     bus_rdata,
    input  logic                  bus_ack
);
    logic [0:0]        state;
    logic              is_load;
    logic              is_store;
    logic              misalign;
    logic              go;
    logic [3:0]        sel;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] load_data;

    assign is_load  = is_load_op(mem_aluop);
    assign is_store = is_store_op(mem_aluop);

`ifdef MEM_ALIGN_CHECK_EN
    assign misalign = (is_half_op(mem_aluop) & mem_addr[0]) |
                      (is_word_op(mem_aluop) & (mem_addr[1:0] != 2'b00));
`else
    assign misalign = 1'b0;
`endif

    assign go = (is_load | is_store) & ~misalign;
    // Releasing the stall in the ack cycle lets upstream advance without re-issuing.
    assign stallreq = (state == IDLE) ? go : ~bus_ack;

    mem_lane_align u_align (
        .aluop      (mem_aluop),
        .addr       (mem_addr[1:0]),
        .store_data (mem_store_data),
        .rdata      (bus_rdata),
        .sel        (sel),
        .wdata      (wdata),
        .load_data  (load_data)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            wb_wd     <= '0;
            wb_wreg   <= WriteDisable;
            wb_wdata  <= '0;
            bus_req   <= 1'b0;
            bus_we    <= 1'b0;
            bus_addr  <= '0;
            bus_sel   <= '0;
            bus_wdata <= '0;
        end else if (state == IDLE) begin
            if (go) begin
                state     <= BUS;
                wb_wreg   <= WriteDisable;
                bus_req   <= 1'b1;
                bus_we    <= is_store;
                bus_addr  <= {mem_addr[ADDR_W-1:2], 2'b00};
                bus_sel   <= sel;
                bus_wdata <= wdata;
            end else begin
                wb_wd    <= mem_wd;
                wb_wreg  <= misalign ? WriteDisable : mem_wreg;
                wb_wdata <= mem_wdata;
            end
        end else if (bus_ack) begin
            state   <= IDLE;
            bus_req <= 1'b0;
            wb_wd   <= mem_wd;
            wb_wreg <= is_load ? mem_wreg : WriteDisable;
            if (is_load)
                wb_wdata <= load_data;
        end else begin
            wb_wreg <= WriteDisable;
        end
    end

`ifdef MEM_ALIGN_CHECK_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            misalign_exc <= 1'b0;
        else
            misalign_exc <= (state == IDLE) & misalign;
    end
`endif
endmodule

// File: tb/tb_mem_access.sv
// tb_mem_access: directed plus randomized checks of mem_access against an arithmetic lane model.
module tb_mem_access;
    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  mem_wd;
    logic        mem_wreg;
    logic [31:0] mem_wdata;
    logic [7:0]  mem_aluop;
    logic [31:0] mem_addr;
    logic [31:0] mem_store_data;
    logic [4:0]  wb_wd;
    logic        wb_wreg;
    logic [31:0] wb_wdata;
    logic        stallreq;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [3:0]  bus_sel;
    logic [31:0] bus_wdata;
    logic [31:0] bus_rdata;
    logic        bus_ack;
`ifdef MEM_ALIGN_CHECK_EN
    logic        misalign_exc;
`endif

    int vec = 0;
    int errs = 0;

    always #5 clk = ~clk;

    mem_access dut (
        .clk(clk), .rst(rst),
        .mem_wd(mem_wd), .mem_wreg(mem_wreg), .mem_wdata(mem_wdata),
        .mem_aluop(mem_aluop), .mem_addr(mem_addr), .mem_store_data(mem_store_data),
        .wb_wd(wb_wd), .wb_wreg(wb_wreg), .wb_wdata(wb_wdata),
        .stallreq(stallreq), .bus_req(bus_req), .bus_we(bus_we),
        .bus_addr(bus_addr), .bus_sel(bus_sel), .bus_wdata(bus_wdata),
`ifdef MEM_ALIGN_CHECK_EN
        .misalign_exc(misalign_exc),
`endif
        .bus_rdata(bus_rdata), .bus_ack(bus_ack)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vec++;
        assert (got === exp) else begin
            errs++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    function automatic int op_size(input logic [7:0] op);
        case (op)
            8'hE0, 8'hE4, 8'hE8: return 1;
            8'hE1, 8'hE5, 8'hE9: return 2;
            default:             return 4;
        endcase
    endfunction

    function automatic int lane_off(input logic [7:0] op, input logic [31:0] addr);
        int s = op_size(op);
        return (int'(addr % 4) / s) * s;
    endfunction

    function automatic logic [3:0] exp_sel(input logic [7:0] op, input logic [31:0] addr);
        int s = op_size(op);
        return 4'(((1 << s) - 1) << (4 - s - lane_off(op, addr)));
    endfunction

    function automatic logic [31:0] exp_wdata(input logic [7:0] op, input logic [31:0] rt);
        int s = op_size(op);
        if (s == 1) return (rt & 32'hFF) * 32'h01010101;
        if (s == 2) return (rt & 32'hFFFF) * 32'h00010001;
        return rt;
    endfunction

    function automatic logic [31:0] exp_load(input logic [7:0] op, input logic [31:0] addr,
                                             input logic [31:0] rdata);
        int s = op_size(op);
        logic [31:0] mask = (s == 4) ? 32'hFFFFFFFF : (32'h1 << (8 * s)) - 32'h1;
        logic [31:0] v = (rdata >> (8 * (4 - s - lane_off(op, addr)))) & mask;
        if ((op == 8'hE0 || op == 8'hE1) && v[8 * s - 1]) v = v | ~mask;
        return v;
    endfunction

    task automatic set_nop();
        mem_aluop = 8'h00; mem_wreg = 1'b0; mem_wd = 5'd0; mem_wdata = 32'h0;
    endtask

    // Entered and left one time unit after a rising edge.
    task automatic pass_op(input logic [7:0] op, input logic [4:0] wd, input logic wreg,
                           input logic [31:0] wdata);
        mem_aluop = op; mem_wd = wd; mem_wreg = wreg; mem_wdata = wdata;
        mem_addr = $urandom; bus_ack = 1'b0;
        @(negedge clk);
        chk("pass_stall", {31'h0, stallreq}, 32'h0);
        @(posedge clk); #1;
        chk("pass_wd", {27'h0, wb_wd}, {27'h0, wd});
        chk("pass_wreg", {31'h0, wb_wreg}, {31'h0, wreg});
        chk("pass_wdata", wb_wdata, wdata);
    endtask

    task automatic mem_op(input logic [7:0] op, input logic [31:0] addr, input logic [31:0] rt,
                          input logic [31:0] rdata, input logic [4:0] wd, input logic wreg,
                          input int waits);
        logic st = op inside {8'hE8, 8'hE9, 8'hEB};
        mem_aluop = op; mem_addr = addr; mem_store_data = rt; mem_wd = wd; mem_wreg = wreg;
        mem_wdata = $urandom; bus_ack = 1'b0;
        @(negedge clk);
        chk("idle_stall", {31'h0, stallreq}, 32'h1);
        @(posedge clk); #1;
        for (int i = 0; i <= waits; i++) begin
            bus_ack = (i == waits);
            bus_rdata = (i == waits) ? rdata : $urandom;
            @(negedge clk);
            chk("bus_req", {31'h0, bus_req}, 32'h1);
            chk("bus_we", {31'h0, bus_we}, {31'h0, st});
            chk("bus_addr", bus_addr, addr & 32'hFFFFFFFC);
            chk("bus_sel", {28'h0, bus_sel}, {28'h0, exp_sel(op, addr)});
            if (st) chk("bus_wdata", bus_wdata, exp_wdata(op, rt));
            chk("bus_wb_wreg", {31'h0, wb_wreg}, 32'h0);
            chk("bus_stall", {31'h0, stallreq}, (i == waits) ? 32'h0 : 32'h1);
            @(posedge clk); #1;
        end
        bus_ack = 1'b0;
        set_nop();
        @(negedge clk);
        chk("done_req", {31'h0, bus_req}, 32'h0);
        chk("done_wd", {27'h0, wb_wd}, {27'h0, wd});
        chk("done_wreg", {31'h0, wb_wreg}, st ? 32'h0 : {31'h0, wreg});
        if (!st) chk("done_wdata", wb_wdata, exp_load(op, addr, rdata));
        @(posedge clk); #1;
    endtask

    initial begin
        logic [7:0] ops [8] = '{8'hE0, 8'hE4, 8'hE1, 8'hE5, 8'hE3, 8'hE8, 8'hE9, 8'hEB};
        rst = 1'b0; bus_ack = 1'b0; bus_rdata = 32'h0; mem_addr = 32'h0; mem_store_data = 32'h0;
        set_nop();
        @(negedge clk);
        chk("rst_wb", {wb_wd, wb_wreg, wb_wdata[25:0]}, 32'h0);
        chk("rst_wdata", wb_wdata, 32'h0);
        chk("rst_bus", {bus_req, bus_we, bus_sel, 26'h0}, 32'h0);
        chk("rst_baddr", bus_addr, 32'h0);
        chk("rst_bwdata", bus_wdata, 32'h0);
`ifdef MEM_ALIGN_CHECK_EN
        chk("rst_exc", {31'h0, misalign_exc}, 32'h0);
`endif
        rst = 1'b1;
        @(posedge clk); #1;

        pass_op(8'h25, 5'd3, 1'b1, 32'h12345678);
        mem_op(8'hE0, 32'h1001, $urandom, 32'h00807F00, 5'd5, 1'b1, 3);
        mem_op(8'hE5, 32'h2002, $urandom, 32'hAAAA8001, 5'd6, 1'b1, 0);
        mem_op(8'hE8, 32'h3003, 32'h000000CD, $urandom, 5'd7, 1'b1, 0);
        mem_op(8'hE3, 32'h0000_5000, $urandom, 32'hDEADBEEF, 5'd8, 1'b1, 1);
        mem_op(8'hE1, 32'h0000_6000, $urandom, 32'h9234_5678, 5'd9, 1'b1, 0);

        // Reset while a store is outstanding.
        mem_aluop = 8'hEB; mem_addr = 32'h7004; mem_store_data = $urandom; mem_wreg = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        chk("midbus_req", {31'h0, bus_req}, 32'h1);
        #2 rst = 1'b0;
        #1;
        chk("async_req", {31'h0, bus_req}, 32'h0);
        chk("async_wreg", {31'h0, wb_wreg}, 32'h0);
        mem_aluop = 8'h25; mem_wd = 5'd7; mem_wreg = 1'b1; mem_wdata = 32'hCAFE0001;
        @(negedge clk);
        rst = 1'b1;
        bus_ack = 1'b1;
        @(negedge clk);
        chk("late_ack_req", {31'h0, bus_req}, 32'h0);
        chk("late_ack_stall", {31'h0, stallreq}, 32'h0);
        chk("late_ack_wreg", {31'h0, wb_wreg}, 32'h1);
        chk("late_ack_wdata", wb_wdata, 32'hCAFE0001);
        bus_ack = 1'b0;
        @(posedge clk); #1;

`ifdef MEM_ALIGN_CHECK_EN
        mem_aluop = 8'hE3; mem_addr = 32'h4002; mem_wreg = 1'b1; mem_wd = 5'd4;
        @(negedge clk);
        chk("mis_stall", {31'h0, stallreq}, 32'h0);
        @(posedge clk); #1;
        set_nop();
        chk("mis_exc", {31'h0, misalign_exc}, 32'h1);
        chk("mis_req", {31'h0, bus_req}, 32'h0);
        chk("mis_wreg", {31'h0, wb_wreg}, 32'h0);
        @(posedge clk); #1;
        chk("mis_exc_pulse", {31'h0, misalign_exc}, 32'h0);
`endif

        for (int k = 0; k < 40; k++) begin
            int idx = $urandom_range(0, 8);
            if (idx == 8) begin
                pass_op(8'h20 + 8'($urandom_range(0, 15)), 5'($urandom), 1'($urandom), $urandom);
            end else begin
                logic [31:0] a = $urandom;
`ifdef MEM_ALIGN_CHECK_EN
                if (op_size(ops[idx]) == 2) a[0] = 1'b0;
                if (op_size(ops[idx]) == 4) a[1:0] = 2'b00;
`endif
                mem_op(ops[idx], a, $urandom, $urandom, 5'($urandom), 1'($urandom),
                       $urandom_range(0, 3));
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end
endmodule
